// File: rtl/and_gate_vector_feeder.sv
// Vector feeder for the registered and_gate: FIFO-buffered (a,b) playback with optional c checking.
// Build option: define AND_GATE_FEEDER_CHECK_EN to enable the check pipe and error counting.
module and_gate_vector_feeder #(
  parameter int DEPTH    = 16,
  parameter int GATE_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
`ifdef AND_GATE_FEEDER_CHECK_EN
  localparam logic [1:0] S_DRAIN = 2'd2;
`endif

  logic [1:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [1:0]       rd_entry;
  logic             empty, full, push, pop, start_acc, cnt_inc;

  // Pointers carry a wrap bit so full and empty are distinguishable at equal addresses.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready;
  assign start_acc = (state_q == S_IDLE) && start && !empty;
  assign pop       = start_acc || ((state_q == S_RUN) && !empty);
  assign rd_entry  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
  end

`ifdef AND_GATE_FEEDER_CHECK_EN
  logic             vld_q [GATE_LAT+1];
  logic             exp_q [GATE_LAT+1];
  logic [CNT_W-1:0] err_q, err_d;
  logic             miss, pipe_idle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pipe_idle = 1'b1;
    for (int i = 0; i <= GATE_LAT; i++) begin
      if (vld_q[i]) pipe_idle = 1'b0;
    end
  end

  assign cnt_inc = vld_q[GATE_LAT];
  assign miss    = cnt_inc && (c != exp_q[GATE_LAT]);

  always_comb begin
    err_d = start_acc ? '0 : err_q;
    if (miss) err_d = sat_inc(err_d);
  end

  // Stage 0 loads with a/b; the last stage lines up with the gate's registered c.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= GATE_LAT; i++) vld_q[i] <= 1'b0;
      err_q <= '0;
    end else begin
      vld_q[0] <= pop;
      for (int i = 1; i <= GATE_LAT; i++) vld_q[i] <= vld_q[i-1];
      err_q <= err_d;
    end
    exp_q[0] <= rd_entry[1] & rd_entry[0];
    for (int i = 1; i <= GATE_LAT; i++) exp_q[i] <= exp_q[i-1];
  end

  assign err_count = err_q;
`else
  logic unused_c;
  assign unused_c  = c & (GATE_LAT > 0);
  assign cnt_inc   = pop;
  assign err_count = '0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start_acc) state_d = S_RUN;
      S_RUN: begin
        if (empty) begin
          a_d = 1'b0;
          b_d = 1'b0;
`ifdef AND_GATE_FEEDER_CHECK_EN
          state_d = S_DRAIN;
`else
          state_d = S_IDLE;
          done    = 1'b1;
`endif
        end
      end
`ifdef AND_GATE_FEEDER_CHECK_EN
      S_DRAIN: begin
        if (pipe_idle) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      a_d = rd_entry[1];
      b_d = rd_entry[0];
    end
  end

  always_comb begin
    vec_d = start_acc ? '0 : vec_q;
    if (cnt_inc) vec_d = vec_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      vec_q    <= vec_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != S_IDLE);
  assign vec_count = vec_q;
endmodule

// File: tb/tb_and_gate_vector_feeder.sv
// Bench for and_gate_vector_feeder: queue-based playback model, table scenarios, random rounds.
module tb_and_gate_vector_feeder;
  localparam int DEPTH    = 16;
  localparam int GATE_LAT = 1;
  localparam int CNT_W    = 16;
`ifdef AND_GATE_FEEDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, start = 1'b0;
  logic in_ready, a, b, busy, done;
  logic c = 1'b0;
  logic [CNT_W-1:0] vec_count, err_count;

  and_gate_vector_feeder #(.DEPTH(DEPTH), .GATE_LAT(GATE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .vec_count(vec_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Registered and_gate with optional stuck-at-0 and per-cycle output flip.
  bit force0 = 1'b0, flip = 1'b0, rand_flip = 1'b0;
  always @(posedge clk) c <= force0 ? 1'b0 : ((a & b) ^ flip);

  int total = 0, bad = 0;

  // Reference model: FIFO contents, playback/drain phase, expected outputs and counts.
  logic [1:0] q[$];
  bit mplay = 0, mdrain = 0, pend = 0, exp_a = 0, exp_b = 0;
  int dwait = 0, m_pops = 0, m_err = 0;

  typedef struct {
    int          n;
    logic [15:0] va;
    logic [15:0] vb;
    bit          fault;
    int          exp_vec;
    int          exp_err;
  } vec_rec_t;
  vec_rec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_done();
    return CHK_EN ? (mdrain && dwait == 0) : (mplay && q.size() == 0);
  endfunction

  task automatic pop_model();
    logic [1:0] e;
    e = q.pop_front();
    exp_a = e[1];
    exp_b = e[0];
    m_pops++;
    pend = 1'b1;
  endtask

  // One clock: drive inputs, advance the model over the edge, then compare at negedge.
  task automatic step(input bit v, input bit va, input bit vb, input bit st);
    bit fl, cv, acc;
    fl = rand_flip ? 1'($urandom_range(0, 1)) : 1'b0;
    if (pend) begin
      cv = force0 ? 1'b0 : ((exp_a & exp_b) ^ fl);
      if (cv != (exp_a & exp_b)) m_err++;
      pend = 1'b0;
    end
    flip = fl; in_valid = v; in_a = va; in_b = vb; start = st;
    acc = v && (q.size() < DEPTH);
    if (mdrain) begin
      if (dwait == 0) mdrain = 1'b0;
      else dwait--;
    end else if (mplay) begin
      if (q.size() > 0) pop_model();
      else begin
        mplay = 1'b0; exp_a = 1'b0; exp_b = 1'b0;
        if (CHK_EN) begin mdrain = 1'b1; dwait = GATE_LAT; end
      end
    end else if (st && q.size() > 0) begin
      mplay = 1'b1; m_pops = 0; m_err = 0;
      pop_model();
    end
    if (acc) q.push_back({va, vb});
    @(posedge clk);
    @(negedge clk);
    chk("a", a, exp_a);
    chk("b", b, exp_b);
    chk("busy", busy, mplay || mdrain);
    chk("done", done, m_done());
    chk("in_ready", in_ready, q.size() < DEPTH);
  endtask

  task automatic run_to_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (m_done()) begin
        seen = 1'b1;
        chk({nm, "_vec"}, vec_count, m_pops);
        chk({nm, "_err"}, err_count, CHK_EN ? m_err : 0);
      end else step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: done got 0 expected 1 within 300 clk", nm);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit v);
    rst = 1'b1; in_valid = v; in_a = 1'b1; in_b = 1'b1; start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    mplay = 0; mdrain = 0; dwait = 0; exp_a = 0; exp_b = 0; pend = 0; m_pops = 0; m_err = 0;
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_in_ready_after", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time got %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 4, va: 16'b1100,  vb: 16'b1010,  fault: 1'b0, exp_vec: 4, exp_err: 0};
    tbl[1] = '{n: 4, va: 16'hF,     vb: 16'hF,     fault: 1'b1, exp_vec: 4, exp_err: 4};
    tbl[2] = '{n: 5, va: 16'b10110, vb: 16'b11010, fault: 1'b1, exp_vec: 5, exp_err: 2};
    tbl[3] = '{n: 1, va: 16'h1,     vb: 16'h1,     fault: 1'b1, exp_vec: 1, exp_err: 1};
    tbl[4] = '{n: 3, va: 16'b111,   vb: 16'b000,   fault: 1'b1, exp_vec: 3, exp_err: 0};
    tbl[5] = '{n: 8, va: 16'h00F0,  vb: 16'h00CC,  fault: 1'b0, exp_vec: 8, exp_err: 0};

    @(negedge clk);
    do_reset(1'b0);

    for (int i = 0; i < 6; i++) begin
      force0 = tbl[i].fault;
      for (int j = 0; j < tbl[i].n; j++) step(1'b1, tbl[i].va[j], tbl[i].vb[j], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_first_a", a, tbl[i].va[0]);
      chk("tbl_first_b", b, tbl[i].vb[0]);
      run_to_done("tbl");
      chk("tbl_vec_const", vec_count, tbl[i].exp_vec);
      chk("tbl_err_const", err_count, CHK_EN ? tbl[i].exp_err : 0);
    end
    force0 = 1'b0;

    // Start while busy must not clear the counts.
    for (int j = 0; j < 6; j++) step(1'b1, 1'b1, 1'(j), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_to_done("busy_start");
    chk("busy_start_vec", vec_count, 6);

    // Reset in the middle of playback with in_valid held high.
    for (int j = 0; j < 6; j++) step(1'b1, 1'(j), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);

    // Start with nothing buffered is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("empty_start_busy", busy, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("empty_start_done", done, 0);

    // Fill to capacity; the 17th offer is refused.
    for (int j = 0; j < 17; j++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (j == 15) chk("fill_ready_at_16", in_ready, 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_to_done("fill");
    chk("fill_vec", vec_count, 16);

    // Streaming: one push per clock during playback keeps a/b bubble-free.
    for (int j = 0; j < 4; j++) step(1'b1, 1'(j >> 1), 1'(j), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 40; j++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    run_to_done("stream");
    chk("stream_vec", vec_count, 44);

    // Random rounds with random c corruption, pushes and stray starts.
    rand_flip = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int j = 0; j < n; j++) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      for (int k = 0; k < 30 && mplay && !m_done(); k++)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      run_to_done("rand");
      while (q.size() > 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_to_done("rand_rest");
      end
    end
    rand_flip = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
